// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, writeback entry and buffer state shared by the writeback stage (ALU_WB_FLAGS_EN adds flag bits to the entry)
package alu_pkg;

  localparam logic [3:0] ALU_HOLD = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_NOT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SHL  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1011;

  // Widest destination index an entry can carry; instances narrow it on output.
  localparam int DEST_MAX_W = 8;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic eq;
  } alu_flags_t;

  typedef struct packed {
    logic [31:0]           result;
    logic [DEST_MAX_W-1:0] dest;
`ifdef ALU_WB_FLAGS_EN
    alu_flags_t            flags;
`endif
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/alu_wb_stage_if.sv
// rtl/alu_wb_stage_if.sv - ALU result intake and register-file writeback handshake bundle
interface alu_wb_stage_if #(
  parameter int REG_IDX_W = 5
);

  logic                 InValid;
  logic                 InReady;
  logic [31:0]          OperandA;
  logic [31:0]          OperandB;
  logic [3:0]           ALUsel;
  logic [31:0]          ALUResult;
  logic [REG_IDX_W-1:0] InDest;

  logic                 OutValid;
  logic                 OutReady;
  logic [31:0]          WbData;
  logic [REG_IDX_W-1:0] WbDest;
  logic                 Carry;
  logic                 Overflow;
  logic                 Equal;
  logic [2:0]           FlagsQ;

  modport master (
    output InValid, OperandA, OperandB, ALUsel, ALUResult, InDest, OutReady,
    input  InReady, OutValid, WbData, WbDest, Carry, Overflow, Equal, FlagsQ
  );

  modport slave (
    input  InValid, OperandA, OperandB, ALUsel, ALUResult, InDest, OutReady,
    output InReady, OutValid, WbData, WbDest, Carry, Overflow, Equal, FlagsQ
  );

endinterface

// File: rtl/alu_flag_calc.sv
// rtl/alu_flag_calc.sv - combinational carry/overflow/equal flags from the ALU operands and opcode
module alu_flag_calc
  import alu_pkg::*;
(
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  alusel,
  output alu_flags_t  flags
);

  logic [32:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        unused_low_bits;

  assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff = operand_a - operand_b;

  // Signed overflow: result sign disagrees with an operand sign the operation should preserve.
  assign add_ovf = (operand_a[31] == operand_b[31]) && (sum[31] != operand_a[31]);
  assign sub_ovf = (operand_a[31] != operand_b[31]) && (diff[31] != operand_a[31]);

  assign unused_low_bits = ^{sum[30:0], diff[30:0]};

  always_comb begin
    flags    = '0;
    flags.eq = (operand_a == operand_b);
    case (alusel)
      ALU_SUB: begin
        flags.carry = (operand_a >= operand_b);
        flags.ovf   = sub_ovf;
      end
      ALU_HOLD, ALU_AND, ALU_OR, ALU_NOT, ALU_XOR, ALU_SHL, ALU_PASS: begin
        flags.carry = 1'b0;
        flags.ovf   = 1'b0;
      end
      default: begin
        flags.carry = sum[32];
        flags.ovf   = add_ovf;
      end
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - 2-entry skid buffer between ALU and register file writeback; ALU_WB_FLAGS_EN enables flag tracking
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int REG_IDX_W = 5
) (
  input logic           Clk,
  input logic           Rst_n,
  alu_wb_stage_if.slave bus
);

  wb_state_e state_q, state_d;
  wb_entry_t head_q, skid_q, new_entry;
  logic      in_ready_q;
  logic      push, pop;
  logic      unused_dest;

  assign push = bus.InValid && in_ready_q;
  assign pop  = (state_q != ST_EMPTY) && bus.OutReady;

`ifdef ALU_WB_FLAGS_EN
  alu_flags_t new_flags, flags_q;

  alu_flag_calc u_flag_calc (
    .operand_a (bus.OperandA),
    .operand_b (bus.OperandB),
    .alusel    (bus.ALUsel),
    .flags     (new_flags)
  );
`else
  logic unused_operands;
  assign unused_operands = ^{bus.OperandA, bus.OperandB, bus.ALUsel};
`endif

  always_comb begin
    new_entry        = '0;
    new_entry.result = bus.ALUResult;
    new_entry.dest   = DEST_MAX_W'(bus.InDest);
`ifdef ALU_WB_FLAGS_EN
    new_entry.flags  = new_flags;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // InReady is registered from the next state so OutReady never reaches it combinationally.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      case (state_q)
        ST_EMPTY: if (push) head_q <= new_entry;
        ST_ONE: begin
          if (push && pop) head_q <= new_entry;
          else if (push)   skid_q <= new_entry;
        end
        ST_FULL:  if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = (state_q != ST_EMPTY);
  assign bus.WbData   = head_q.result;
  assign bus.WbDest   = head_q.dest[REG_IDX_W-1:0];
  assign unused_dest  = ^head_q.dest;

`ifdef ALU_WB_FLAGS_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)   flags_q <= '0;
    else if (pop) flags_q <= head_q.flags;
  end

  assign bus.Carry    = head_q.flags.carry;
  assign bus.Overflow = head_q.flags.ovf;
  assign bus.Equal    = head_q.flags.eq;
  assign bus.FlagsQ   = flags_q;
`else
  assign bus.Carry    = 1'b0;
  assign bus.Overflow = 1'b0;
  assign bus.Equal    = 1'b0;
  assign bus.FlagsQ   = 3'b000;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - directed and random checks of alu_wb_stage against a queue model (ALU_WB_FLAGS_EN selects flag expectations)
module tb_alu_wb_stage;
  import alu_pkg::*;

  localparam int W = 5;
`ifdef ALU_WB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_wb_stage_if #(.REG_IDX_W(W)) bus ();
  alu_wb_stage #(.REG_IDX_W(W)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0]  res;
    logic [W-1:0] dest;
    logic [2:0]   fl;
  } ent_t;

  ent_t       q[$];
  logic       m_ready;
  logic [2:0] m_flagsq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags {Overflow,Carry,Equal} from the arithmetic meaning of each opcode.
  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
    longint sa, sb, s;
    logic   c, v;
    if (!FLAGS_ON) return 3'b000;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    case (sel)
      4'b0010: begin
        c = (a >= b);
        s = sa - sb;
        v = (s != longint'($signed(s[31:0])));
      end
      4'b0000, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1011: ;
      default: begin
        c = (({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF);
        s = sa + sb;
        v = (s != longint'($signed(s[31:0])));
      end
    endcase
    return {v, c, (a == b)};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic [31:0] res, input logic [W-1:0] dest);
    bus.InValid   = v;
    bus.OperandA  = a;
    bus.OperandB  = b;
    bus.ALUsel    = sel;
    bus.ALUResult = res;
    bus.InDest    = dest;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".outvalid"}, bus.OutValid, q.size() != 0);
    chk({tag, ".inready"}, bus.InReady, m_ready);
    chk({tag, ".flagsq"}, bus.FlagsQ, m_flagsq);
    if (q.size() != 0) begin
      chk({tag, ".wbdata"}, bus.WbData, q[0].res);
      chk({tag, ".wbdest"}, bus.WbDest, q[0].dest);
      chk({tag, ".flags"}, {bus.Overflow, bus.Carry, bus.Equal}, q[0].fl);
    end
  endtask

  // One clock: model the handshake at the edge, then check at the falling edge.
  task automatic tick(input string tag);
    bit   push, pop;
    ent_t e;
    push   = bus.InValid && m_ready;
    pop    = (q.size() != 0) && bus.OutReady;
    e.res  = bus.ALUResult;
    e.dest = bus.InDest;
    e.fl   = ref_flags(bus.OperandA, bus.OperandB, bus.ALUsel);
    @(posedge Clk);
    if (pop) begin
      m_flagsq = q[0].fl;
      void'(q.pop_front());
    end
    if (push) q.push_back(e);
    m_ready = (q.size() != 2);
    @(negedge Clk);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] a, b;
    m_ready  = 1'b0;
    m_flagsq = 3'b000;
    bus.OutReady = 1'b0;
    drive(1'b0, 32'h0, 32'h0, ALU_HOLD, 32'h0, '0);

    #1 Rst_n = 1'b0;
    #1;
    chk("reset.outvalid", bus.OutValid, 1'b0);
    chk("reset.inready", bus.InReady, 1'b0);
    chk("reset.wbdata", bus.WbData, 32'h0);
    chk("reset.wbdest", bus.WbDest, 5'h0);
    chk("reset.flags", {bus.Overflow, bus.Carry, bus.Equal}, 3'b000);
    chk("reset.flagsq", bus.FlagsQ, 3'b000);

    @(negedge Clk);
    Rst_n = 1'b1;
    chk("release.inready_low", bus.InReady, 1'b0);
    tick("release");
    chk("release.inready_high", bus.InReady, 1'b1);

    drive(1'b1, 32'hFFFF_FFFF, 32'h1, ALU_ADD, 32'h0, 5'd3);
    tick("r035");
    chk("r035.outvalid", bus.OutValid, 1'b1);
    chk("r035.wbdata", bus.WbData, 32'h0);
    chk("r035.wbdest", bus.WbDest, 5'd3);
    chk("r035.carry", bus.Carry, FLAGS_ON);
    chk("r035.ovf", bus.Overflow, 1'b0);
    chk("r035.eq", bus.Equal, 1'b0);

    // Push with pop in state ONE: new entry becomes head, popped flags land in FlagsQ.
    bus.OutReady = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 32'h8000_0000, 5'd4);
    tick("r036a");
    chk("r036a.wbdata", bus.WbData, 32'h8000_0000);
    chk("r036a.ovf", bus.Overflow, FLAGS_ON);
    chk("r036a.carry", bus.Carry, 1'b0);
    chk("r038.flagsq", bus.FlagsQ, FLAGS_ON ? 3'b010 : 3'b000);
    drive(1'b1, 32'd5, 32'd5, ALU_SUB, 32'h0, 5'd5);
    tick("r036b");
    chk("r036b.eq", bus.Equal, FLAGS_ON);
    chk("r036b.carry", bus.Carry, FLAGS_ON);
    chk("r036b.ovf", bus.Overflow, 1'b0);
    chk("r036b.flagsq", bus.FlagsQ, FLAGS_ON ? 3'b100 : 3'b000);
    drive(1'b0, 32'h0, 32'h0, ALU_HOLD, 32'h0, '0);
    tick("drain");
    chk("drain.flagsq", bus.FlagsQ, FLAGS_ON ? 3'b011 : 3'b000);

    bus.OutReady = 1'b0;
    drive(1'b1, 32'd10, 32'd20, ALU_XOR, 32'h11, 5'd7);
    tick("r037.p1");
    drive(1'b1, 32'd30, 32'd30, ALU_AND, 32'h22, 5'd8);
    tick("r037.p2");
    chk("r037.full_inready", bus.InReady, 1'b0);
    drive(1'b1, 32'd1, 32'd2, ALU_ADD, 32'h33, 5'd9);
    tick("r037.p3");
    chk("r037.head_kept", bus.WbData, 32'h11);
    drive(1'b0, 32'h0, 32'h0, ALU_HOLD, 32'h0, '0);
    bus.OutReady = 1'b1;
    tick("r037.pop1");
    chk("r037.inready_back", bus.InReady, 1'b1);
    chk("r037.second_head", bus.WbData, 32'h22);
    tick("r037.pop2");
    chk("r037.empty", bus.OutValid, 1'b0);

    bus.OutReady = 1'b0;
    drive(1'b1, 32'd4, 32'd9, ALU_SUB, 32'hAA, 5'd1);
    tick("r039.f1");
    drive(1'b1, 32'd9, 32'd4, ALU_SUB, 32'hBB, 5'd2);
    tick("r039.f2");
    drive(1'b0, 32'h0, 32'h0, ALU_HOLD, 32'h0, '0);
    #2 Rst_n = 1'b0;
    #1;
    chk("r039.async_outvalid", bus.OutValid, 1'b0);
    chk("r039.async_inready", bus.InReady, 1'b0);
    chk("r039.async_wbdata", bus.WbData, 32'h0);
    q.delete();
    m_ready  = 1'b0;
    m_flagsq = 3'b000;
    @(negedge Clk);
    Rst_n = 1'b1;
    bus.OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("r039.post");
      chk("r039.no_stale", bus.OutValid, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = a;
        1: begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 3); end
        2: begin a = 32'h8000_0000; b = 32'h8000_0000 - $urandom_range(0, 2); end
        3: begin a = 32'hFFFF_FFFF; b = $urandom; end
        default: b = $urandom;
      endcase
      drive($urandom_range(0, 2) != 0, a, b, 4'($urandom_range(0, 15)), $urandom,
            W'($urandom_range(0, 31)));
      bus.OutReady = ($urandom_range(0, 3) != 0);
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter REG_IDX_W, default 5, width of the destination register index.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port InValid, input, 1 bit: the upstream ALU result is valid.
REQ-005 SHALL have port InReady, output, 1 bit: the stage can accept an entry.
REQ-006 SHALL have ports OperandA and OperandB, input, 32 bits each: the operands the ALU consumed.
REQ-007 SHALL have port ALUsel, input, 4 bits: the ALU operation code.
REQ-008 SHALL have port ALUResult, input, 32 bits: the ALU output.
REQ-009 SHALL have port InDest, input, REG_IDX_W bits: the destination register index.
REQ-010 SHALL have port OutValid, input side none, output, 1 bit: a writeback entry is present.
REQ-011 SHALL have port OutReady, input, 1 bit: the register file accepts the entry.
REQ-012 SHALL have ports WbData (output, 32 bits) and WbDest (output, REG_IDX_W bits): the head entry's result and destination.
REQ-013 SHALL have ports Carry, Overflow and Equal, output, 1 bit each: the head entry's flags.
REQ-014 SHALL have port FlagsQ, output, 3 bits {Overflow,Carry,Equal}: the flags of the last entry popped.

Function
REQ-015 SHALL form a 2-entry skid buffer; an entry is {result, dest, flags}; push = InValid&&InReady; pop = OutValid&&OutReady.
REQ-016 SHALL have states EMPTY, ONE and FULL.
REQ-017 SHALL transition EMPTY->ONE on push.
REQ-018 SHALL transition ONE->FULL on push without pop, ONE->EMPTY on pop without push, and stay in ONE on push with pop, where the new entry becomes head.
REQ-019 SHALL transition FULL->ONE on pop, with the skid entry becoming head.
REQ-020 SHALL drive InReady as a register equal to (state!=FULL) so that it has no combinational path from OutReady; InReady reasserts the cycle after a FULL pop.
REQ-021 SHALL drive OutValid = (state!=EMPTY) and present the head entry on WbData, WbDest and the flag outputs; latency from push to OutValid is 1 cycle.
REQ-022 SHALL hold the head entry stable while OutValid&&!OutReady, and SHALL never drop or duplicate an entry.
REQ-023 SHALL compute flags at push from OperandA, OperandB and ALUsel: for ALUsel 0001 and unlisted codes (add), Carry = bit 32 of the 33-bit A+B and Overflow = signed add overflow.
REQ-024 SHALL, for ALUsel 0010 (sub), set Carry = (A >= B unsigned), i.e. no borrow, and Overflow = signed subtract overflow.
REQ-025 SHALL, for ALUsel 0000, 0101, 0110, 0111, 1000, 1001 and 1011, set Carry=0 and Overflow=0.
REQ-026 SHALL set Equal = (OperandA==OperandB) for every ALUsel.
REQ-027 SHALL load FlagsQ on every pop with the popped entry's flags, and otherwise hold it.

Reset
REQ-028 SHALL, on Rst_n low, immediately force state=EMPTY, InReady=0, OutValid=0, WbData=0, WbDest=0, Carry=Overflow=Equal=0 and FlagsQ=0.
REQ-029 SHALL raise InReady to 1 on the first clock edge after reset deasserts.
REQ-030 SHALL, when reset occurs mid-operation, discard all buffered entries without emitting them.

Configuration
REQ-031 SHALL compute flags per REQ-023..026 when macro ALU_WB_FLAGS_EN is defined.
REQ-032 SHALL, when ALU_WB_FLAGS_EN is undefined, tie Carry, Overflow, Equal and FlagsQ to 0, store no flag bits in the buffer, and leave the handshake unchanged.

Structure
REQ-033 SHALL take from shared package alu_pkg: the ALUsel encoding constants (ADD=0001, SUB=0010, AND=0101, OR=0110, NOT=0111, XOR=1000, SHL=1001, PASS=1011, HOLD=0000), the entry struct typedef, and the state enum.
REQ-034 SHALL place flag computation in the purely combinational sub-module alu_flag_calc.

Verification
REQ-035 SHALL cover: reset, then push A=0xFFFFFFFF, B=1, ALUsel=0001, Result=0, Dest=3 -> next cycle OutValid=1, WbData=0, WbDest=3, Carry=1, Overflow=0, Equal=0.
REQ-036 SHALL cover: push A=0x7FFFFFFF, B=1, ALUsel=0001 -> Overflow=1, Carry=0; push A=5, B=5, ALUsel=0010 -> Equal=1, Carry=1, Overflow=0.
REQ-037 SHALL cover: OutReady=0 with 3 pushes offered -> 2 accepted, InReady=0 after the second; OutReady=1 -> entries pop in order, InReady=1 one cycle after the first pop.
REQ-038 SHALL cover: in state ONE, push and pop in the same cycle -> state stays ONE, the next head is the new entry, and FlagsQ equals the popped entry's flags.
REQ-039 SHALL cover: Rst_n pulsed low while FULL -> OutValid=0 asynchronously, and no stale entry appears after release.
REQ-040 SHALL cover: with ALU_WB_FLAGS_EN undefined, the REQ-035 stimulus gives WbData=0 and all flags 0.
